// File: rtl/memory_controller.sv
// Word-addressed RAM with a request sequencer: latches an access in IDLE, inserts
// WAIT_STATES wait cycles in ACCESS, then reports done/error for one DONE cycle.
module memory_controller #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_BITS   = 9,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  rd_req,
  input  logic                  wr_req,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_done,
  output logic                  mem_busy,
  output logic                  mem_err
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;
  localparam int unsigned CntW  = 4;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  wr_op_q, wr_op_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ram_we;
  logic                  out_of_range;
  logic [ADDR_BITS-1:0]  ram_idx;

  logic [DATA_WIDTH-1:0] ram [Depth];

  assign ram_idx      = addr_q[ADDR_BITS-1:0];
  assign out_of_range = |addr_q[DATA_WIDTH-1:ADDR_BITS];

  // State register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rd_req ^ wr_req) begin
          state_d = StAccess;
        end else if (rd_req && wr_req) begin
          state_d = StDone;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode: done/busy come straight from state, err is gated by the latched flag
  always_comb begin
    mem_busy  = (state_q != StIdle);
    mem_done  = (state_q == StDone);
    mem_err   = (state_q == StDone) && err_q;
    mem_rdata = rdata_q;
  end

  // Datapath next-state and array strobe
  always_comb begin
    cnt_d   = cnt_q;
    err_d   = err_q;
    wr_op_d = wr_op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ram_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_req ^ wr_req) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wr_op_d = wr_req;
          cnt_d   = CntW'(WAIT_STATES);
          err_d   = 1'b0;
        end else if (rd_req && wr_req) begin
          err_d = 1'b1;
        end
      end
      StAccess: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (out_of_range) begin
          err_d = 1'b1;
          if (!wr_op_q) begin
            rdata_d = '0;
          end
        end else if (wr_op_q) begin
          ram_we = 1'b1;
        end else begin
          rdata_d = ram[ram_idx];
        end
      end
      StDone: begin
        err_d = 1'b0;
      end
      default: begin
        err_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wr_op_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wr_op_q <= wr_op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Array has no reset; the strobe is decoded from state so clear kills a pending write
  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram[ram_idx] <= wdata_q;
    end
  end

endmodule
